float_mul_top: RTL and testbench

FLOAT_MUL_TOP -- requirements
Module: float_mul_top

---
 rtl/float_mul_pkg.sv | 36 +++
 rtl/booth_mul_24.sv | 45 ++++
 rtl/float_mul_top.sv | 158 +++++++++++++++
 tb/tb_float_mul_top.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/float_mul_pkg.sv
// Shared constants and types for the single-precision floating-point multiplier.
package float_mul_pkg;

    localparam int          BIAS    = 127;
    localparam int          EXP_MAX = 255;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        OvfNone      = 2'b00,
        OvfOverflow  = 2'b01,
        OvfUnderflow = 2'b10,
        OvfInvalid   = 2'b11
    } ovf_e;

    typedef enum logic {
        RndNearestEven = 1'b0,
        RndTruncate    = 1'b1
    } rnd_e;

    typedef enum logic [1:0] {
        SpNone,
        SpZero,
        SpInf,
        SpNan
    } special_e;

    // Sideband that travels alongside the significand data through every stage.
    typedef struct packed {
        logic              valid;
        logic              sign;
        special_e          special;
        rnd_e              rnd;
        logic signed [9:0] exp;
    } side_t;

endpackage

// File: rtl/booth_mul_24.sv
// 24x24 unsigned radix-4 Booth multiplier with a registered 48-bit product.
module booth_mul_24 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [23:0] a_i,
    input  logic [23:0] b_i,
    output logic [47:0] p_o
);

    // Two zero bits on top keep the last recoded digit non-negative for unsigned operands.
    logic [26:0]        recode;
    logic signed [47:0] a_ext;
    logic signed [47:0] pp;
    logic signed [47:0] acc;
    logic [47:0]        p_q;

    assign recode = {2'b00, b_i, 1'b0};
    assign a_ext  = $signed({24'd0, a_i});

    always_comb begin
        acc = '0;
        pp  = '0;
        for (int i = 0; i < 13; i++) begin
            case (recode[2*i +: 3])
                3'b001, 3'b010: pp = a_ext;
                3'b011:         pp = a_ext <<< 1;
                3'b100:         pp = -(a_ext <<< 1);
                3'b101, 3'b110: pp = -a_ext;
                default:        pp = '0;
            endcase
            acc = acc + (pp <<< (2 * i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_q <= '0;
        end else begin
            p_q <= acc;
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/float_mul_top.sv
// Pipelined IEEE-754 single-precision multiplier: unpack, Booth multiply, normalise, round.
module float_mul_top
    import float_mul_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [31:0] float_a,
    input  logic [31:0] float_b,
    input  logic        round_cofig,
    output logic [31:0] float_p,
    output logic [1:0]  overflow
);

    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    side_t       s1_side_d, s1_side_q;
    logic [23:0] s1_sig_a_q, s1_sig_b_q;
    side_t       s2_side_q;
    logic [47:0] s2_prod;
    side_t       s3_side_d, s3_side_q;
    logic [23:0] s3_mant_d, s3_mant_q;
    logic        s3_guard_d, s3_guard_q;
    logic        s3_sticky_d, s3_sticky_q;

    logic        round_up;
    logic [24:0] mant_r;
    logic signed [9:0] exp_f;
    logic [22:0] frac;
    logic [31:0] float_p_d, float_p_q;
    ovf_e        overflow_d, overflow_q;

    assign ea = float_a[30:23];
    assign eb = float_b[30:23];
    assign fa = float_a[22:0];
    assign fb = float_b[22:0];

    assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);

    always_comb begin
        s1_side_d       = '0;
        s1_side_d.valid = 1'b1;
        s1_side_d.sign  = float_a[31] ^ float_b[31];
        s1_side_d.rnd   = rnd_e'(round_cofig);
        s1_side_d.exp   = 10'(int'(ea) + int'(eb) - BIAS);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            s1_side_d.special = SpNan;
        end else if (a_inf || b_inf) begin
            s1_side_d.special = SpInf;
        end else if (a_zero || b_zero) begin
            s1_side_d.special = SpZero;
        end else begin
            s1_side_d.special = SpNone;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1_side_q  <= '0;
            s1_sig_a_q <= '0;
            s1_sig_b_q <= '0;
            s2_side_q  <= '0;
        end else begin
            s1_side_q  <= s1_side_d;
            s1_sig_a_q <= {1'b1, fa};
            s1_sig_b_q <= {1'b1, fb};
            s2_side_q  <= s1_side_q;
        end
    end

    booth_mul_24 u_booth (
        .clk_i (sys_clk),
        .rst_i (sys_rst),
        .a_i   (s1_sig_a_q),
        .b_i   (s1_sig_b_q),
        .p_o   (s2_prod)
    );

    always_comb begin
        s3_side_d = s2_side_q;
        if (s2_prod[47]) begin
            s3_mant_d     = s2_prod[47:24];
            s3_guard_d    = s2_prod[23];
            s3_sticky_d   = |s2_prod[22:0];
            s3_side_d.exp = s2_side_q.exp + 10'sd1;
        end else begin
            s3_mant_d   = s2_prod[46:23];
            s3_guard_d  = s2_prod[22];
            s3_sticky_d = |s2_prod[21:0];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s3_side_q   <= '0;
            s3_mant_q   <= '0;
            s3_guard_q  <= 1'b0;
            s3_sticky_q <= 1'b0;
        end else begin
            s3_side_q   <= s3_side_d;
            s3_mant_q   <= s3_mant_d;
            s3_guard_q  <= s3_guard_d;
            s3_sticky_q <= s3_sticky_d;
        end
    end

    // Rounding and the special-case override are resolved into the output register.
    always_comb begin
        round_up   = (s3_side_q.rnd == RndNearestEven) && s3_guard_q &&
                     (s3_sticky_q || s3_mant_q[0]);
        mant_r     = {1'b0, s3_mant_q} + 25'(round_up);
        exp_f      = s3_side_q.exp + (mant_r[24] ? 10'sd1 : 10'sd0);
        frac       = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
        float_p_d  = '0;
        overflow_d = OvfNone;
        if (s3_side_q.valid) begin
            case (s3_side_q.special)
                SpNan: begin
                    float_p_d  = QNAN;
                    overflow_d = OvfInvalid;
                end
                SpInf:  float_p_d = {s3_side_q.sign, 8'hFF, 23'd0};
                SpZero: float_p_d = {s3_side_q.sign, 31'd0};
                default: begin
                    if (int'(exp_f) >= EXP_MAX) begin
                        float_p_d  = {s3_side_q.sign, 8'hFF, 23'd0};
                        overflow_d = OvfOverflow;
                    end else if (int'(exp_f) <= 0) begin
                        float_p_d  = {s3_side_q.sign, 31'd0};
                        overflow_d = OvfUnderflow;
                    end else begin
                        float_p_d = {s3_side_q.sign, exp_f[7:0], frac};
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            float_p_q  <= '0;
            overflow_q <= OvfNone;
        end else begin
            float_p_q  <= float_p_d;
            overflow_q <= overflow_d;
        end
    end

    assign float_p  = float_p_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_float_mul_top.sv
// Self-checking bench for float_mul_top: directed vector table, reset flush and random traffic.
module tb_float_mul_top;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [31:0] float_a;
    logic [31:0] float_b;
    logic        round_cofig;
    logic [31:0] float_p;
    logic [1:0]  overflow;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] p;
        logic [1:0]  ov;
        string       tag;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        r;
        logic [31:0] p;
        logic [1:0]  ov;
        string       tag;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];

    float_mul_top dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .float_a     (float_a),
        .float_b     (float_b),
        .round_cofig (round_cofig),
        .float_p     (float_p),
        .overflow    (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference: exact integer product, then round/classify straight from the IEEE rules.
    function automatic logic [33:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic r);
        logic              s;
        logic [7:0]        ea, eb;
        logic [22:0]       fa, fb;
        logic              an, bn, ai, bi, az, bz;
        longint unsigned   ma, mb, m, mant, rem, half;
        int                e, sh;
        s  = a[31] ^ b[31];
        ea = a[30:23];
        eb = b[30:23];
        fa = a[22:0];
        fb = b[22:0];
        an = (ea == 8'hFF) && (fa != 0);
        bn = (eb == 8'hFF) && (fb != 0);
        ai = (ea == 8'hFF) && (fa == 0);
        bi = (eb == 8'hFF) && (fb == 0);
        az = (ea == 8'h00);
        bz = (eb == 8'h00);
        if (an || bn || (ai && bz) || (bi && az)) return {2'b11, 32'h7FC0_0000};
        if (ai || bi) return {2'b00, s, 8'hFF, 23'd0};
        if (az || bz) return {2'b00, s, 31'd0};
        ma = 64'(fa) + 64'h80_0000;
        mb = 64'(fb) + 64'h80_0000;
        m  = ma * mb;
        e  = int'(ea) + int'(eb) - 127;
        sh = (m >= (64'd1 << 47)) ? 24 : 23;
        e  = e + sh - 23;
        mant = m >> sh;
        rem  = m & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        if (!r && (rem > half || (rem == half && mant[0]))) mant = mant + 1;
        if (mant == (64'd1 << 24)) begin
            mant = mant >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {2'b01, s, 8'hFF, 23'd0};
        if (e <= 0) return {2'b10, s, 31'd0};
        return {2'b00, s, e[7:0], mant[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] f;
        int          k;
        k = int'($urandom_range(0, 15));
        f = 23'($urandom);
        if (k == 0) f = '0;
        if (k <= 1) e = 8'h00;
        else if (k == 2) begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 1) f = '0;
        end else if (k == 3) e = 8'($urandom);
        else e = 8'(127 + int'($urandom_range(0, 120)) - 60);
        return {1'($urandom), e, f};
    endfunction

    task automatic check(input logic [31:0] ep, input logic [1:0] eov, input string tag);
        total++;
        if (float_p !== ep || overflow !== eov) begin
            bad++;
            $display("FAIL %s: float_p=%h overflow=%b, expected float_p=%h overflow=%b",
                     tag, float_p, overflow, ep, eov);
        end
    endtask

    // One clock: drive, take the edge, then compare whatever was issued three edges ago.
    task automatic cycle(input logic [31:0] a, input logic [31:0] b, input logic r,
                         input logic rst, input logic [31:0] ep, input logic [1:0] eov,
                         input string tag);
        exp_t e;
        float_a     = a;
        float_b     = b;
        round_cofig = r;
        sys_rst     = rst;
        @(posedge sys_clk);
        #1;
        if (rst) begin
            check(32'h0, 2'b00, "reset");
            sb.delete();
            repeat (3) sb.push_back('{p: 32'h0, ov: 2'b00, tag: "post-reset flush"});
        end else begin
            sb.push_back('{p: ep, ov: eov, tag: tag});
            if (sb.size() >= 4) begin
                e = sb.pop_front();
                check(e.p, e.ov, e.tag);
            end
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic r,
                         input string tag);
        logic [33:0] res;
        res = ref_mul(a, b, r);
        cycle(a, b, r, 1'b0, res[31:0], res[33:32], tag);
    endtask

    initial begin
        vecs[0] = '{32'h3FC0_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 2'b00, "basic 1.5x2"};
        vecs[1] = '{32'h4040_0000, 32'hC000_0000, 1'b0, 32'hC0C0_0000, 2'b00, "sign 3x-2"};
        vecs[2] = '{32'h40B3_3333, 32'h4006_6666, 1'b0, 32'h413C_28F5, 2'b00, "5.6x2.1 rne"};
        vecs[3] = '{32'h40B3_3333, 32'h4006_6666, 1'b1, 32'h413C_28F4, 2'b00, "5.6x2.1 trunc"};
        vecs[4] = '{32'h7F00_0000, 32'h7F00_0000, 1'b0, 32'h7F80_0000, 2'b01, "overflow"};
        vecs[5] = '{32'h0080_0000, 32'h0080_0000, 1'b0, 32'h0000_0000, 2'b10, "underflow"};
        vecs[6] = '{32'h7F80_0000, 32'h0000_0000, 1'b0, 32'h7FC0_0000, 2'b11, "inf x zero"};
        vecs[7] = '{32'hFF80_0000, 32'h4000_0000, 1'b0, 32'hFF80_0000, 2'b00, "-inf x 2"};

        cycle(32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 2'b00, "reset");
        cycle(32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 2'b00, "reset");

        // Each vector in isolation, drained by idle zero products.
        foreach (vecs[i]) begin
            cycle(vecs[i].a, vecs[i].b, vecs[i].r, 1'b0, vecs[i].p, vecs[i].ov, vecs[i].tag);
            repeat (3) issue(32'h0, 32'h0, 1'b0, "idle");
        end

        // Back-to-back issue: results must emerge in order on consecutive cycles.
        foreach (vecs[i]) begin
            cycle(vecs[i].a, vecs[i].b, vecs[i].r, 1'b0, vecs[i].p, vecs[i].ov,
                  {vecs[i].tag, " b2b"});
        end
        repeat (3) issue(32'h0, 32'h0, 1'b0, "idle");

        // Reset with three products in flight: none of them may surface afterwards.
        issue(32'h3FC0_0000, 32'h4000_0000, 1'b0, "inflight0");
        issue(32'h4040_0000, 32'hC000_0000, 1'b0, "inflight1");
        issue(32'h7F00_0000, 32'h7F00_0000, 1'b0, "inflight2");
        cycle(32'h4040_0000, 32'h4040_0000, 1'b0, 1'b1, 32'h0, 2'b00, "reset");
        issue(32'h4000_0000, 32'h4000_0000, 1'b1, "first after reset");
        repeat (4) issue(32'h0, 32'h0, 1'b0, "idle after reset");

        for (int n = 0; n < 1500; n++) begin
            issue(rand_fp(), rand_fp(), 1'($urandom), "random");
        end
        repeat (3) issue(32'h0, 32'h0, 1'b0, "drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
